// File: rtl/megarom_mapper_engine.sv
`default_nettype none
// ============================================================================
// Module   : megarom_mapper_engine
// Brief    : Runtime-selectable MSX MegaROM mapper (ASCII8/16, Konami, SCC,
//            plain 32 KB) with req/ack memory port and bus wait generation.
// Revision : 1.0 - initial release
// ============================================================================
module megarom_mapper_engine #(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int BANK_BITS      = 8
) (
    input  logic                        CLK,
    input  logic                        RESET_n,
    input  logic                        BUS_RESET_n,
    input  logic [2:0]                  MODE,
    input  logic [ADDR_BIT_WIDTH-1:0]   MEM_TOP,
    input  logic [BANK_BITS-1:0]        ROM_MASK,
    input  logic                        SRAM_EN,
    input  logic [ADDR_BIT_WIDTH-1:0]   SRAM_TOP,
    input  logic                        SLTSL_n,
    input  logic                        MERQ_n,
    input  logic                        RD_n,
    input  logic                        WR_n,
    input  logic [15:0]                 ADDR,
    input  logic [7:0]                  DIN,
    output logic [7:0]                  DOUT,
    output logic                        BUSDIR_n,
    output logic                        WAIT_n,
    output logic                        MEM_REQ,
    output logic                        MEM_WE,
    output logic [ADDR_BIT_WIDTH-1:0]   MEM_ADDR,
    output logic [7:0]                  MEM_DIN,
    input  logic                        MEM_ACK,
    input  logic [7:0]                  MEM_DOUT,
    output logic [4*BANK_BITS-1:0]      BANK
);

    localparam logic [2:0] c_ASCII8  = 3'd0;
    localparam logic [2:0] c_ASCII16 = 3'd1;
    localparam logic [2:0] c_KONAMI  = 3'd2;
    localparam logic [2:0] c_SCC     = 3'd3;
    localparam logic [2:0] c_PLAIN   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_rd_s, r_rd_p, r_wr_s, r_wr_p;
    logic [15:0]                 r_addr;
    logic [7:0]                  r_din;
    logic [7:0]                  r_dout;
    logic                        r_is_rd;
    logic                        r_abort;
    logic [BANK_BITS-1:0]        r_bank [0:3];

    logic                        w_rd, w_wr;
    logic                        w_rd_edge, w_wr_edge;
    logic [2:0]                  w_mode;
    logic                        w_in_window;
    logic                        w_bank_we;
    logic [1:0]                  w_bank_idx;
    logic [BANK_BITS-1:0]        w_bank_val;
    logic [1:0]                  w_rd_idx;
    logic [BANK_BITS-1:0]        w_sel_bank;
    logic                        w_sram_sel;
    logic                        w_sram_wr;
    logic                        w_start;
    logic                        w_live;
    logic [ADDR_BIT_WIDTH-1:0]   w_rom_off;
    logic [ADDR_BIT_WIDTH-1:0]   w_mem_addr;

    assign w_rd = ~SLTSL_n & ~MERQ_n & ~RD_n;
    assign w_wr = ~SLTSL_n & ~MERQ_n & ~WR_n;

    // Strobes, address and data share one sampling stage so decode stays coherent
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_rd_s <= 1'b0;
            r_rd_p <= 1'b0;
            r_wr_s <= 1'b0;
            r_wr_p <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_rd_s <= w_rd;
            r_rd_p <= r_rd_s;
            r_wr_s <= w_wr;
            r_wr_p <= r_wr_s;
            r_addr <= ADDR;
            r_din  <= DIN;
        end
    end

    assign w_rd_edge   = r_rd_s & ~r_rd_p;
    assign w_wr_edge   = r_wr_s & ~r_wr_p;
    assign w_mode      = (MODE > c_PLAIN) ? c_PLAIN : MODE;
    assign w_in_window = (r_addr[15:14] == 2'b01) || (r_addr[15:14] == 2'b10);

    always_comb begin
        w_bank_we  = 1'b0;
        w_bank_idx = 2'd0;
        if (w_wr_edge && BUS_RESET_n) begin
            case (w_mode)
                c_ASCII8: begin
                    if (r_addr[15:13] == 3'b011) begin
                        w_bank_we  = 1'b1;
                        w_bank_idx = r_addr[12:11];
                    end
                end
                c_ASCII16: begin
                    if (r_addr[15:11] == 5'b01100) begin
                        w_bank_we  = 1'b1;
                        w_bank_idx = 2'd0;
                    end else if (r_addr[15:11] == 5'b01110) begin
                        w_bank_we  = 1'b1;
                        w_bank_idx = 2'd1;
                    end
                end
                c_KONAMI: begin
                    if (r_addr[15:13] == 3'b011 || r_addr[15:13] == 3'b100 ||
                        r_addr[15:13] == 3'b101) begin
                        w_bank_we  = 1'b1;
                        w_bank_idx = 2'(r_addr[15:13] - 3'd2);
                    end
                end
                c_SCC: begin
                    if (r_addr[12:11] == 2'b10 && r_addr[15:13] >= 3'd2 &&
                        r_addr[15:13] <= 3'd5) begin
                        w_bank_we  = 1'b1;
                        w_bank_idx = 2'(r_addr[15:13] - 3'd2);
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM-capable ASCII8 keeps the out-of-mask bits so they can flag SRAM
    assign w_bank_val = (w_mode == c_ASCII8 && SRAM_EN) ? DIN[BANK_BITS-1:0]
                                                          : (DIN[BANK_BITS-1:0] & ROM_MASK);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < 4; i++) r_bank[i] <= BANK_BITS'(i);
        end else if (!BUS_RESET_n) begin
            for (int i = 0; i < 4; i++) r_bank[i] <= BANK_BITS'(i);
        end else if (w_bank_we) begin
            r_bank[w_bank_idx] <= w_bank_val;
        end
    end

    assign w_rd_idx   = (w_mode == c_ASCII16) ? {1'b0, r_addr[15]} : {r_addr[15], r_addr[13]};
    assign w_sel_bank = r_bank[w_rd_idx];
    assign w_sram_sel = (w_mode == c_ASCII8) && SRAM_EN && (|(w_sel_bank & ~ROM_MASK));

    always_comb begin
        case (w_mode)
            c_ASCII16: w_rom_off = ADDR_BIT_WIDTH'({w_sel_bank, r_addr[13:0]});
            c_PLAIN:   w_rom_off = ADDR_BIT_WIDTH'({r_addr[15:14] - 2'b01, r_addr[13:0]});
            default:   w_rom_off = ADDR_BIT_WIDTH'({w_sel_bank, r_addr[12:0]});
        endcase
    end

    assign w_mem_addr = w_sram_sel ? (SRAM_TOP + ADDR_BIT_WIDTH'(r_addr[12:0]))
                                   : (MEM_TOP + w_rom_off);
    assign w_sram_wr  = w_wr_edge && w_in_window && r_addr[15] && w_sram_sel;
    assign w_start    = BUS_RESET_n && (r_state == S_IDLE) &&
                        ((w_rd_edge && w_in_window) || w_sram_wr);
    assign w_live     = BUS_RESET_n & ~r_abort;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        MEM_REQ     = 1'b0;
        WAIT_n      = 1'b1;
        BUSDIR_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                MEM_REQ  = 1'b1;
                WAIT_n   = ~w_live;
                BUSDIR_n = ~(w_live & r_is_rd);
                if (MEM_ACK) w_state_nxt = w_live ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                BUSDIR_n = ~(w_live & r_is_rd);
                if (!r_rd_s && !r_wr_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An aborted request still completes its handshake but its data is dropped
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            MEM_ADDR <= '0;
            MEM_WE   <= 1'b0;
            MEM_DIN  <= '0;
            r_is_rd  <= 1'b0;
            r_abort  <= 1'b0;
            r_dout   <= '0;
        end else if (w_start) begin
            MEM_ADDR <= w_mem_addr;
            MEM_WE   <= w_sram_wr;
            r_is_rd  <= ~w_sram_wr;
            r_abort  <= 1'b0;
            r_dout   <= '0;
            if (w_sram_wr) MEM_DIN <= r_din;
        end else if (r_state == S_REQ) begin
            if (!BUS_RESET_n) r_abort <= 1'b1;
            if (MEM_ACK && w_live && r_is_rd) r_dout <= MEM_DOUT;
        end
    end

    assign DOUT = BUSDIR_n ? 8'h00 : r_dout;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank_out
        assign BANK[gi*BANK_BITS +: BANK_BITS] = r_bank[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_megarom_mapper_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_megarom_mapper_engine
// Brief    : Scoreboard bench for megarom_mapper_engine with a delayed-ack memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_megarom_mapper_engine;

    localparam int AW = 24;
    localparam int BB = 8;

    logic            CLK = 1'b0;
    logic            RESET_n, BUS_RESET_n;
    logic [2:0]      MODE;
    logic [AW-1:0]   MEM_TOP, SRAM_TOP;
    logic [BB-1:0]   ROM_MASK;
    logic            SRAM_EN;
    logic            SLTSL_n, MERQ_n, RD_n, WR_n;
    logic [15:0]     ADDR;
    logic [7:0]      DIN;
    logic            MEM_ACK;
    logic [7:0]      MEM_DOUT;
    wire  [7:0]      DOUT;
    wire             BUSDIR_n, WAIT_n, MEM_REQ, MEM_WE;
    wire  [AW-1:0]   MEM_ADDR;
    wire  [7:0]      MEM_DIN;
    wire  [4*BB-1:0] BANK;

    megarom_mapper_engine #(.ADDR_BIT_WIDTH(AW), .BANK_BITS(BB)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n), .MODE(MODE),
        .MEM_TOP(MEM_TOP), .ROM_MASK(ROM_MASK), .SRAM_EN(SRAM_EN), .SRAM_TOP(SRAM_TOP),
        .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_ACK(MEM_ACK), .MEM_DOUT(MEM_DOUT), .BANK(BANK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    din;
    } txn_t;

    txn_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   req_count = 0;
    int   ack_delay = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: checks each request against the scoreboard, acks after ack_delay
    initial begin
        txn_t e;
        MEM_ACK  = 1'b0;
        MEM_DOUT = 8'h00;
        forever begin
            @(posedge CLK); #1;
            if (MEM_REQ === 1'b1) begin
                req_count++;
                check_eq("req_expected", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("mem_addr", MEM_ADDR, e.addr);
                    check_eq("mem_we", MEM_WE, e.we);
                    if (e.we) check_eq("mem_din", MEM_DIN, e.din);
                end
                if (ack_delay > 0) begin
                    repeat (ack_delay) @(posedge CLK);
                    #1;
                end
                MEM_ACK  = 1'b1;
                MEM_DOUT = MEM_ADDR[7:0] ^ 8'hA5;
                @(posedge CLK); #1;
                MEM_ACK  = 1'b0;
                MEM_DOUT = 8'h00;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_mode(input logic [2:0] m, input logic [AW-1:0] top,
                            input logic [BB-1:0] mask, input logic sen, input logic [AW-1:0] stop);
        BUS_RESET_n = 1'b0;
        MODE = m; MEM_TOP = top; ROM_MASK = mask; SRAM_EN = sen; SRAM_TOP = stop;
        tick(2);
        BUS_RESET_n = 1'b1;
        tick(1);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        int cyc;
        ADDR = a; DIN = d; SLTSL_n = 1'b0; MERQ_n = 1'b0; WR_n = 1'b0;
        tick(3);
        cyc = 0;
        while (WAIT_n !== 1'b1 && cyc < 60) begin tick(1); cyc++; end
        check_eq("wr_wait_bound", 64'(cyc < 60), 64'd1);
        SLTSL_n = 1'b1; MERQ_n = 1'b1; WR_n = 1'b1;
        tick(3);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [AW-1:0] exp_addr);
        int   cyc;
        txn_t t;
        logic [7:0] exp_data;
        t.addr = exp_addr; t.we = 1'b0; t.din = 8'h00;
        sb_q.push_back(t);
        exp_data = exp_addr[7:0] ^ 8'hA5;
        ADDR = a; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        cyc = 0;
        while (MEM_REQ !== 1'b1 && cyc < 10) begin tick(1); cyc++; end
        check_eq("req_cycle", cyc, 2);
        check_eq("wait_low", WAIT_n, 1'b0);
        check_eq("busdir_low", BUSDIR_n, 1'b0);
        check_eq("dout_pre", DOUT, 8'h00);
        while (MEM_REQ === 1'b1 && cyc < 80) begin tick(1); cyc++; end
        check_eq("latency", cyc, 3 + ack_delay);
        check_eq("wait_rel", WAIT_n, 1'b1);
        check_eq("dout", DOUT, exp_data);
        SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1;
        tick(1);
        check_eq("dout_hold", DOUT, exp_data);
        tick(1);
        check_eq("busdir_rel", BUSDIR_n, 1'b1);
        check_eq("dout_rel", DOUT, 8'h00);
        tick(1);
    endtask

    initial begin
        int   cyc;
        int   rc;
        txn_t t;
        RESET_n = 1'b0; BUS_RESET_n = 1'b1; MODE = 3'd0; MEM_TOP = '0; SRAM_TOP = '0;
        ROM_MASK = '1; SRAM_EN = 1'b0; SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1;
        WR_n = 1'b1; ADDR = 16'h0000; DIN = 8'h00;
        tick(3);
        check_eq("rst_dout", DOUT, 8'h00);
        check_eq("rst_busdir", BUSDIR_n, 1'b1);
        check_eq("rst_wait", WAIT_n, 1'b1);
        check_eq("rst_req", MEM_REQ, 1'b0);
        check_eq("rst_we", MEM_WE, 1'b0);
        check_eq("rst_addr", MEM_ADDR, 24'h0);
        check_eq("rst_din", MEM_DIN, 8'h00);
        check_eq("rst_bank", BANK, 32'h03020100);
        RESET_n = 1'b1;
        tick(2);

        // ASCII8 banked reads with immediate and delayed ack
        set_mode(3'd0, 24'h100000, 8'h1F, 1'b0, 24'h0);
        bus_write(16'h6800, 8'h05);
        check_eq("a8_b1", BANK[15:8], 8'h05);
        bus_read(16'h6123, 24'h10A123);
        ack_delay = 3;
        bus_read(16'hA456, 24'h106456);
        ack_delay = 0;

        // ASCII16
        set_mode(3'd1, 24'h100000, 8'h1F, 1'b0, 24'h0);
        bus_write(16'h7000, 8'h03);
        check_eq("a16_b1", BANK[15:8], 8'h03);
        bus_read(16'h8001, 24'h10C001);
        bus_read(16'h4000, 24'h100000);

        // Konami-SCC decode
        set_mode(3'd3, 24'h100000, 8'hFF, 1'b0, 24'h0);
        bus_write(16'h6000, 8'h55);
        check_eq("scc_nochg", BANK, 32'h03020100);
        bus_write(16'h9000, 8'h07);
        check_eq("scc_b2", BANK[23:16], 8'h07);
        bus_read(16'h9234, 24'h10F234);

        // Konami: b0 is not writable
        set_mode(3'd2, 24'h100000, 8'hFF, 1'b0, 24'h0);
        bus_write(16'h4000, 8'h09);
        check_eq("kon_b0", BANK[7:0], 8'h00);
        bus_write(16'hA000, 8'h0B);
        check_eq("kon_b3", BANK[31:24], 8'h0B);
        bus_read(16'hA010, 24'h116010);

        // ASCII8 SRAM write and read
        set_mode(3'd0, 24'h100000, 8'h0F, 1'b1, 24'h200000);
        bus_write(16'h7000, 8'h10);
        check_eq("sram_b2", BANK[23:16], 8'h10);
        t.addr = 24'h200010; t.we = 1'b1; t.din = 8'hAA;
        sb_q.push_back(t);
        rc = req_count;
        bus_write(16'h8010, 8'hAA);
        check_eq("sram_wr_req", req_count, rc + 1);
        bus_read(16'h8020, 24'h200020);

        // Same write with SRAM disabled touches no memory
        set_mode(3'd0, 24'h100000, 8'h0F, 1'b0, 24'h200000);
        bus_write(16'h7000, 8'h10);
        check_eq("nosram_b2", BANK[23:16], 8'h00);
        rc = req_count;
        bus_write(16'h8010, 8'hAA);
        check_eq("nosram_noreq", req_count, rc);

        // Mask applied to bank value; read outside window ignored
        set_mode(3'd0, 24'h100000, 8'h07, 1'b0, 24'h0);
        bus_write(16'h6000, 8'hFF);
        check_eq("mask_b0", BANK[7:0], 8'h07);
        rc = req_count;
        ADDR = 16'hC000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        tick(4);
        check_eq("out_busdir", BUSDIR_n, 1'b1);
        check_eq("out_noreq", req_count, rc);
        SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1;
        tick(2);

        // Plain 32 KB, including modulo wrap of the base add; mode 6 acts as plain
        set_mode(3'd4, 24'h0F0000, 8'hFF, 1'b0, 24'h0);
        bus_read(16'h8123, 24'h0F4123);
        set_mode(3'd6, 24'hFFFF00, 8'hFF, 1'b0, 24'h0);
        bus_read(16'h4200, 24'h000100);

        // Bus reset while a slow request is in flight
        set_mode(3'd0, 24'h100000, 8'h1F, 1'b0, 24'h0);
        bus_write(16'h6000, 8'h04);
        check_eq("abort_b0", BANK[7:0], 8'h04);
        t.addr = 24'h108000; t.we = 1'b0; t.din = 8'h00;
        sb_q.push_back(t);
        ack_delay = 20;
        ADDR = 16'h4000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        cyc = 0;
        while (MEM_REQ !== 1'b1 && cyc < 10) begin tick(1); cyc++; end
        check_eq("abort_req", MEM_REQ, 1'b1);
        BUS_RESET_n = 1'b0;
        tick(3);
        check_eq("abort_req_held", MEM_REQ, 1'b1);
        check_eq("abort_busdir", BUSDIR_n, 1'b1);
        check_eq("abort_wait", WAIT_n, 1'b1);
        check_eq("abort_banks", BANK, 32'h03020100);
        BUS_RESET_n = 1'b1;
        tick(1);
        check_eq("abort_busdir_post", BUSDIR_n, 1'b1);
        cyc = 0;
        while (MEM_REQ === 1'b1 && cyc < 60) begin tick(1); cyc++; end
        check_eq("abort_ack_bound", 64'(cyc < 60), 64'd1);
        check_eq("abort_dout", DOUT, 8'h00);
        check_eq("abort_busdir_end", BUSDIR_n, 1'b1);
        SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1;
        ack_delay = 0;
        tick(3);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
